// File: rtl/bsg_wormhole_packet_arbiter_rr_if.sv
// Link bundle between the packet sources / downstream port and the round-robin
// wormhole arbiter. The arbiter uses the slave modport, the driving side uses master.
interface bsg_wormhole_packet_arbiter_rr_if #(
  parameter int inputs_p = 2,
  parameter int width_p  = 32
);
  localparam int id_width_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1;

  logic [inputs_p-1:0]         v_i;
  logic [inputs_p*width_p-1:0] data_i;
  logic [inputs_p-1:0]         yumi_o;
  logic                        v_o;
  logic [width_p-1:0]          data_o;
  logic                        ready_and_i;
  logic [id_width_lp-1:0]      grant_id_o;
  logic                        locked_o;

  modport slave (
    input  v_i, data_i, ready_and_i,
    output yumi_o, v_o, data_o, grant_id_o, locked_o
  );

  modport master (
    output v_i, data_i, ready_and_i,
    input  yumi_o, v_o, data_o, grant_id_o, locked_o
  );
endinterface

// File: rtl/bsg_wormhole_packet_arbiter_rr.sv
// Round-robin wormhole arbiter: a header win locks the output until its last body flit.
// Optional per-input packet counters are enabled by BSG_WORMHOLE_PACKET_ARBITER_STATS_EN.
module bsg_wormhole_packet_arbiter_rr #(
  parameter int inputs_p           = 2,
  parameter int width_p            = 32,
  parameter int payload_len_bits_p = 4,
  parameter int len_offset_p       = 0
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_wormhole_packet_arbiter_rr_if.slave link
`ifdef BSG_WORMHOLE_PACKET_ARBITER_STATS_EN
  ,
  output logic [inputs_p*16-1:0] pkt_count_o
`endif
);

  localparam int id_w = (inputs_p > 1) ? $clog2(inputs_p) : 1;
  localparam logic [id_w:0]   num_lp  = (id_w+1)'(inputs_p);
  localparam logic [id_w-1:0] last_lp = id_w'(inputs_p - 1);
  localparam logic [payload_len_bits_p-1:0] one_lp = payload_len_bits_p'(1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                        state_r, state_n;
  logic [id_w-1:0]               rr_ptr_r, rr_ptr_n;
  logic [id_w-1:0]               owner_r, owner_n;
  logic [payload_len_bits_p-1:0] remaining_r, remaining_n;

  logic [width_p-1:0]            flits [inputs_p];
  logic [id_w-1:0]               winner;
  logic [id_w-1:0]               sel;
  logic [width_p-1:0]            sel_flit;
  logic [payload_len_bits_p-1:0] hdr_len;
  logic                          out_v;
  logic                          xfer;

  function automatic logic [id_w-1:0] wrap_inc(input logic [id_w-1:0] x);
    return (x == last_lp) ? '0 : x + 1'b1;
  endfunction

  for (genvar i = 0; i < inputs_p; i++) begin : g_flit
    assign flits[i] = link.data_i[i*width_p +: width_p];
  end

  // First valid input at or after rr_ptr, wrapping around.
  always_comb begin
    logic [id_w:0] pos;
    logic          found;
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < inputs_p; k++) begin
      pos = {1'b0, rr_ptr_r} + (id_w+1)'(k);
      if (pos >= num_lp) pos = pos - num_lp;
      if (!found && link.v_i[pos[id_w-1:0]]) begin
        winner = pos[id_w-1:0];
        found  = 1'b1;
      end
    end
  end

  assign sel      = (state_r == LOCKED) ? owner_r : winner;
  assign sel_flit = flits[sel];
  assign hdr_len  = sel_flit[len_offset_p +: payload_len_bits_p];
  assign out_v    = !reset_i && ((state_r == LOCKED) ? link.v_i[owner_r] : |link.v_i);
  assign xfer     = out_v && link.ready_and_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      remaining_r <= '0;
    end else begin
      state_r     <= state_n;
      rr_ptr_r    <= rr_ptr_n;
      owner_r     <= owner_n;
      remaining_r <= remaining_n;
    end
  end

  always_comb begin
    state_n     = state_r;
    rr_ptr_n    = rr_ptr_r;
    owner_n     = owner_r;
    remaining_n = remaining_r;
    case (state_r)
      IDLE: begin
        if (xfer) begin
          if (hdr_len == '0) begin
            rr_ptr_n = wrap_inc(winner);
          end else begin
            state_n     = LOCKED;
            owner_n     = winner;
            remaining_n = hdr_len;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          remaining_n = remaining_r - one_lp;
          if (remaining_r == one_lp) begin
            state_n  = IDLE;
            rr_ptr_n = wrap_inc(owner_r);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    link.v_o        = out_v;
    link.data_o     = sel_flit;
    link.grant_id_o = sel;
    link.locked_o   = !reset_i && (state_r == LOCKED);
    link.yumi_o     = xfer ? (inputs_p'(1) << sel) : '0;
  end

`ifdef BSG_WORMHOLE_PACKET_ARBITER_STATS_EN
  // A packet completes on a zero-length header in IDLE or the last body flit in LOCKED.
  logic final_flit;
  assign final_flit = xfer && ((state_r == IDLE) ? (hdr_len == '0) : (remaining_r == one_lp));

  for (genvar i = 0; i < inputs_p; i++) begin : g_cnt
    logic [15:0] cnt_r;
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        cnt_r <= '0;
      end else if (final_flit && (sel == id_w'(i)) && (cnt_r != 16'hFFFF)) begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
    assign pkt_count_o[i*16 +: 16] = cnt_r;
  end
`endif

endmodule
